// File: rtl/uart_pkg.sv
// Shared types for the UART receive controller.
// Optional parity stage is compiled in with UART_RX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    ,
    S_PARITY = 3'd4
`endif
  } state_t;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

endpackage

// File: rtl/rx_fifo.sv
// Receive byte FIFO, DEPTH x 8, power-of-two depth.
// Push while full is accepted only when a pop happens on the same edge.
module rx_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr;
  logic          rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr    = push & (~full | pop);
  assign rd_en = pop & ~empty;
  assign head  = mem[rptr];

  // storage write, no reset needed on the data array
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr)    wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      case ({wr, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver with FIFO, bus registers and level interrupt.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DIV   = 2604,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rxd,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [15:0] HALF = 16'(DIV / 2);
  localparam logic [15:0] FULL = 16'(DIV);

  logic [1:0]    sync;
  logic [1:0]    filled;
  logic          rxd_s;
  logic          armed;
  state_t        state;
  state_t        state_n;
  logic [15:0]   cnt;
  logic          tick;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_ok;
  logic          frame_push;
  logic          ferr_set;
  logic          perr_set;
  logic          push_q;
  logic [7:0]    byte_q;
  logic          ferr;
  logic          ovf;
  logic          perr;
  logic          ie;
  logic          eie;
  logic          pop;
  logic          clr;
  logic          ovf_set;
  logic          full;
  logic          empty;
  logic [7:0]    head;
  logic [CW-1:0] count;
  logic          unused_wd;

  assign rxd_s     = sync[1];
  assign tick      = (cnt == 16'd1);
  assign pop       = re & (addr == ADDR_DATA) & ~empty;
  assign clr       = we & (addr == ADDR_STATUS) & wd[0];
  assign ovf_set   = push_q & full & ~pop;
  assign unused_wd = ^wd[31:2];

  // two-flop synchronizer, idles high out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync   <= 2'b11;
      filled <= 2'b00;
    end else begin
      sync   <= {sync[0], uart_rxd};
      filled <= {filled[0], 1'b1};
    end
  end

  // a start edge needs a genuinely sampled high line before it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed <= 1'b0;
    end else if (state == S_IDLE && state_n == S_START) begin
      armed <= 1'b0;
    end else if (filled[1] && rxd_s) begin
      armed <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // FSM next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (armed && !rxd_s) state_n = S_START;
      S_START:
        if (tick) state_n = rxd_s ? S_IDLE : S_DATA;
      S_DATA:
        if (tick && bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_n = S_PARITY;
`else
          state_n = S_STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
      S_PARITY:
        if (tick) state_n = S_STOP;
`endif
      S_STOP:
        if (tick) state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  // FSM outputs: frame accept and error strobes
  always_comb begin
    frame_push = 1'b0;
    ferr_set   = 1'b0;
    perr_set   = 1'b0;
    unique case (state)
      S_STOP:
        if (tick) begin
          frame_push = rxd_s & par_ok;
          ferr_set   = ~rxd_s;
        end
`ifdef UART_RX_PARITY_EN
      S_PARITY:
        if (tick) perr_set = (rxd_s != ^shift);
`endif
      default: ;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  assign par_ok = ~par_bad;

  // remember a parity mismatch until the frame ends
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 par_bad <= 1'b0;
    else if (state == S_IDLE)  par_bad <= 1'b0;
    else if (perr_set)         par_bad <= 1'b1;
  end
`else
  assign par_ok = 1'b1;
`endif

  // bit timer, bit counter and LSB-first shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= HALF;
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
    end else begin
      if (state == S_IDLE) begin
        cnt     <= HALF;
        bit_cnt <= 3'd0;
      end else if (tick) begin
        cnt <= FULL;
      end else begin
        cnt <= cnt - 16'd1;
      end
      if (state == S_DATA && tick) begin
        shift   <= {rxd_s, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // stage the finished byte so it lands one edge after the stop sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_q <= 1'b0;
      byte_q <= 8'h00;
    end else begin
      push_q <= frame_push;
      byte_q <= shift;
    end
  end

  rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_q),
    .din   (byte_q),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // sticky error flags; a new error wins over a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ferr <= 1'b0;
      ovf  <= 1'b0;
      perr <= 1'b0;
    end else begin
      ferr <= (ferr & ~clr) | ferr_set;
      ovf  <= (ovf & ~clr) | ovf_set;
      perr <= (perr & ~clr) | perr_set;
    end
  end

  // control register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie  <= 1'b0;
      eie <= 1'b0;
    end else if (we && addr == ADDR_CTRL) begin
      ie  <= wd[0];
      eie <= wd[1];
    end
  end

  // registered interrupt level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else irq <= (ie & ~empty) | (eie & (ferr | ovf | perr));
  end

  // read mux
  always_comb begin
    rd = 32'h0;
    unique case (addr)
      ADDR_DATA:   rd = {24'h0, empty ? 8'h00 : head};
      ADDR_STATUS: rd = {23'h0, perr, ferr, ovf, 5'(count), ~empty};
      ADDR_CTRL:   rd = {30'h0, eie, ie};
      default:     rd = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at DIV=16, DEPTH=4.
// Each task drives one scenario and checks its own results.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        uart_rxd;
  logic [1:0]  addr;
  logic        we;
  logic        re;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DIV(16), .DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .uart_rxd (uart_rxd),
    .addr     (addr),
    .we       (we),
    .re       (re),
    .wd       (wd),
    .rd       (rd),
    .irq      (irq)
  );

  task automatic bit_period(input logic v);
    uart_rxd = v;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(b[i]);
    bit_period(stop);
    bit_period(1'b1);
  endtask

  task automatic bus_read(input logic [1:0] a, input logic p,
                          output logic [31:0] v);
    addr = a;
    re   = p;
    #1 v = rd;
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    wd   = d;
    we   = 1'b1;
    @(negedge clk);
    we = 1'b0;
    wd = 32'h0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset = 1'b1; uart_rxd = 1'b1;
    addr = 2'd0; we = 1'b0; re = 1'b0; wd = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq got=%b exp=0", irq);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    bus_read(2'd1, 1'b0, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL reset_status got=%h exp=0", v);
    end
    bus_read(2'd2, 1'b0, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL reset_ctrl got=%h exp=0", v);
    end
    bus_read(2'd0, 1'b1, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", v);
    end
  endtask

  task automatic test_single;
    logic [31:0] v;
    send_frame(8'hA5, 1'b1);
    bus_read(2'd1, 1'b0, v);
    checks++;
    if (v !== 32'h3) begin
      failures++;
      $display("FAIL single_status got=%h exp=3", v);
    end
    bus_read(2'd0, 1'b1, v);
    checks++;
    if (v !== 32'hA5) begin
      failures++;
      $display("FAIL single_data got=%h exp=a5", v);
    end
    bus_read(2'd1, 1'b0, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL single_status_pop got=%h exp=0", v);
    end
  endtask

  task automatic test_overflow;
    logic [31:0] v;
    logic [7:0]  exp;
    for (int i = 1; i <= 5; i++) send_frame(8'(i * 17), 1'b1);
    bus_read(2'd1, 1'b0, v);
    checks++;
    if (v !== 32'h49) begin
      failures++;
      $display("FAIL ovf_status got=%h exp=49", v);
    end
    for (int i = 1; i <= 4; i++) begin
      exp = 8'(i * 17);
      bus_read(2'd0, 1'b1, v);
      checks++;
      if (v !== {24'h0, exp}) begin
        failures++;
        $display("FAIL ovf_data%0d got=%h exp=%h", i, v, exp);
      end
    end
    bus_read(2'd1, 1'b0, v);
    checks++;
    if (v !== 32'h40) begin
      failures++;
      $display("FAIL ovf_drained got=%h exp=40", v);
    end
    bus_write(2'd1, 32'h1);
    bus_read(2'd1, 1'b0, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL ovf_clear got=%h exp=0", v);
    end
  endtask

  task automatic test_framing;
    logic [31:0] v;
    send_frame(8'h3C, 1'b0);
    bus_read(2'd1, 1'b0, v);
    checks++;
    if (v !== 32'h80) begin
      failures++;
      $display("FAIL ferr_status got=%h exp=80", v);
    end
    bus_write(2'd1, 32'h1);
    bus_read(2'd1, 1'b0, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL ferr_clear got=%h exp=0", v);
    end
  endtask

  task automatic test_glitch;
    logic [31:0] v;
    uart_rxd = 1'b0;
    repeat (4) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (40) @(negedge clk);
    bus_read(2'd1, 1'b0, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL glitch_status got=%h exp=0", v);
    end
    send_frame(8'h5A, 1'b1);
    bus_read(2'd0, 1'b1, v);
    checks++;
    if (v !== 32'h5A) begin
      failures++;
      $display("FAIL glitch_next got=%h exp=5a", v);
    end
  endtask

  task automatic test_irq;
    logic [31:0] v;
    logic        found;
    bus_write(2'd2, 32'h1);
    bus_read(2'd2, 1'b0, v);
    checks++;
    if (v !== 32'h1) begin
      failures++;
      $display("FAIL irq_ctrl got=%h exp=1", v);
    end
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(1'(8'h55 >> i));
    uart_rxd = 1'b1;
    addr = 2'd1;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (rd[5:1] == 5'd1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL irq_count_timeout got=0 exp=1");
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_same_cycle got=%b exp=0", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_next_cycle got=%b exp=1", irq);
    end
    repeat (16) @(negedge clk);
    bus_read(2'd0, 1'b1, v);
    checks++;
    if (v !== 32'h55) begin
      failures++;
      $display("FAIL irq_data got=%h exp=55", v);
    end
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_pop_edge got=%b exp=1", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_after_pop got=%b exp=0", irq);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    send_frame(8'h11, 1'b1);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL mid_irq_before got=%b exp=1", irq);
    end
    bit_period(1'b0);
    bit_period(1'b1);
    bit_period(1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    uart_rxd = 1'b1;
    #1;
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL mid_irq_reset got=%b exp=0", irq);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    bus_read(2'd1, 1'b0, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL mid_status got=%h exp=0", v);
    end
    bus_read(2'd2, 1'b0, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL mid_ctrl got=%h exp=0", v);
    end
    send_frame(8'h81, 1'b1);
    bus_read(2'd1, 1'b0, v);
    checks++;
    if (v !== 32'h3) begin
      failures++;
      $display("FAIL mid_new_status got=%h exp=3", v);
    end
    bus_read(2'd0, 1'b1, v);
    checks++;
    if (v !== 32'h81) begin
      failures++;
      $display("FAIL mid_new_data got=%h exp=81", v);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL mid_irq_after got=%b exp=0", irq);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_framing();
    test_glitch();
    test_irq();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 2604, meaning clk cycles per bit (legal range 4..65535).
REQ-002 SHALL have parameter DEPTH, default 4, meaning receive FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port uart_rxd, input, 1, asynchronous serial line, idle high.
REQ-006 SHALL have port addr, input, 2, word select (bus address bits [3:2]).
REQ-007 SHALL have port we, input, 1, bus write strobe.
REQ-008 SHALL have port re, input, 1, bus read strobe (drives FIFO pop).
REQ-009 SHALL have port wd, input, 32, bus write data.
REQ-010 SHALL have port rd, output, 32, bus read data, combinational from addr.
REQ-011 SHALL have port irq, output, 1, level interrupt to the CPU.

Function
REQ-012 SHALL pass uart_rxd through a 2-flop synchronizer before any use.
REQ-013 SHALL implement FSM IDLE, START, DATA, STOP (plus PARITY, see Configuration).
REQ-014 SHALL leave IDLE for START when synchronized rxd is 0; bit counter loaded with DIV/2.
REQ-015 SHALL at START midpoint go to DATA if rxd is 0, else back to IDLE (glitch reject, nothing recorded).
REQ-016 SHALL in DATA sample rxd every DIV cycles, 8 bits, LSB first, then go to STOP.
REQ-017 SHALL at STOP sample: 1 -> push byte, 0 -> drop byte and set sticky FERR; then IDLE.
REQ-018 SHALL on push with FIFO full (and no same-cycle pop) drop the byte and set sticky OVF.
REQ-019 SHALL on same-cycle push and pop when full perform both; count unchanged; OVF not set.
REQ-020 SHALL make a pushed byte visible in STATUS count on the edge after the stop-bit sample edge.
REQ-021 SHALL map addr 0 DATA: rd = {24'b0, FIFO head}; re with FIFO nonempty pops on that edge; re when empty returns 0 and changes nothing.
REQ-022 SHALL map addr 1 STATUS: rd = {23'b0, PERR, FERR, OVF, count[4:0], nonempty}; we with wd[0]=1 clears all sticky errors.
REQ-023 SHALL map addr 2 CTRL: bit0 IE, bit1 EIE; readable; written by we.
REQ-024 SHALL map addr 3 to read 0; writes ignored.
REQ-025 SHALL drive irq = (IE & nonempty) | (EIE & (FERR|OVF|PERR)), registered, one-cycle latency.

Reset
REQ-026 SHALL on reset (any time, mid-frame included) force FSM to IDLE, FIFO empty, PERR/FERR/OVF/IE/EIE = 0, irq = 0, synchronizer flops = 1.
REQ-027 SHALL, after reset deasserts, start no frame until rxd is seen high then low.

Configuration
REQ-028 SHALL, with UART_RX_PARITY_EN defined, insert state PARITY between DATA and STOP sampling one even-parity bit; mismatch drops the byte and sets sticky PERR.
REQ-029 SHALL, without UART_RX_PARITY_EN, omit PARITY; PERR reads 0.

Structure
REQ-030 SHALL place FSM state encoding and register offsets (DATA=0, STATUS=1, CTRL=2) in shared package uart_pkg.
REQ-031 SHALL implement the FIFO as sub-module rx_fifo (DEPTH x 8, push/pop/full/empty/count).

Verification
REQ-032 SHALL test DIV=16: frame 0xA5, correct stop bit -> STATUS count=1; DATA read returns 0x000000A5; count=0 after pop.
REQ-033 SHALL test 5 frames with no reads (DEPTH=4) -> count=4, OVF=1; reads return frames 1..4 in order.
REQ-034 SHALL test frame 0x3C with stop bit 0 -> FERR=1, count=0; write STATUS wd=1 -> FERR=0.
REQ-035 SHALL test rxd low pulse of 4 cycles -> FSM returns to IDLE, count stays 0, no flag.
REQ-036 SHALL test IE=1 then frame 0x55 -> irq=1 one cycle after count=1; pop -> irq=0 next cycle.
REQ-037 SHALL test reset asserted mid-DATA -> immediately IDLE, irq=0; next clean frame 0x81 received correctly.
